reg_scoreboard_file: RTL and testbench

Architectural register file with per-register pending-write scoreboard for the micro-op core. Sits between decode/issue and the execute stage. Consumes 8-bit register IDs (`reg_id_t` encoding: real registers `8'h80`–`8'h93`, fake registers below `8'h80`) and 72-bit `reg_val_t` writebacks (6 flag bits `{cf,zf,sf,of,pf,af}` over a 64-bit value). Produces resolved operands one cycle after issue and stalls issue on read-after-write and write-after-write hazards.

---
 rtl/reg_scoreboard_file_if.sv | 31 +++
 rtl/reg_scoreboard_file.sv | 149 ++++++++++++++
 tb/tb_reg_scoreboard_file.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_file_if.sv
// Issue / operand / writeback bundle for reg_scoreboard_file.
// Issue accepts on a rising edge with issue_valid && issue_ready; op_valid and wb_valid are one-cycle strobes with no ready.
interface reg_scoreboard_file_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_src_a;
  logic [7:0]  issue_src_b;
  logic [7:0]  issue_dst;
  logic [63:0] issue_imm;
  logic [63:0] issue_rip;
  logic        op_valid;
  logic [71:0] opa_val;
  logic [71:0] opb_val;
  logic        wb_valid;
  logic [7:0]  wb_dst;
  logic [71:0] wb_val;
  logic        err_bad_reg;
  logic        err_wb_unpend;

  modport master (
    output issue_valid, issue_src_a, issue_src_b, issue_dst, issue_imm, issue_rip,
    output wb_valid, wb_dst, wb_val,
    input  issue_ready, op_valid, opa_val, opb_val, err_bad_reg, err_wb_unpend
  );

  modport slave (
    input  issue_valid, issue_src_a, issue_src_b, issue_dst, issue_imm, issue_rip,
    input  wb_valid, wb_dst, wb_val,
    output issue_ready, op_valid, opa_val, opb_val, err_bad_reg, err_wb_unpend
  );
endinterface

// File: rtl/reg_scoreboard_file.sv
// Register file with per-register pending-write counters; stalls issue on RAW/WAW hazards.
// Optional macro REG_WB_BYPASS_EN forwards a same-cycle writeback to a waiting source (zero-bubble RAW).
module reg_scoreboard_file #(
  parameter int REG_FILE_SIZE = 20,
  parameter int PEND_W        = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  reg_scoreboard_file_if.slave bus
);
  // Fake IDs: rnil=00, rv0=01, rsyscall=02 read as 0; rimm=03, rip=04, rv8=05; 06..7F unmapped.
  localparam logic [7:0]        ID_RIMM  = 8'h03;
  localparam logic [7:0]        ID_RIP   = 8'h04;
  localparam logic [7:0]        ID_RV8   = 8'h05;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [71:0]       rf_q   [REG_FILE_SIZE];
  logic [71:0]       rf_d   [REG_FILE_SIZE];
  logic [PEND_W-1:0] pend_q [REG_FILE_SIZE];
  logic [PEND_W-1:0] pend_d [REG_FILE_SIZE];
  logic              op_valid_q, op_valid_d;
  logic [71:0]       opa_q, opa_d, opb_q, opb_d;
  logic              err_bad_q, err_bad_d, err_unpend_q, err_unpend_d;

  logic              a_real, b_real, dst_real, wb_real;
  logic [PEND_W-1:0] a_pend, b_pend, dst_pend, wb_pend;
  logic [71:0]       a_rf, b_rf;
  logic              a_hit, b_hit, a_ok, b_ok, dst_ok, accept;

  function automatic logic is_real(input logic [7:0] id);
    return id[7] && (int'(id[6:0]) < REG_FILE_SIZE);
  endfunction

  function automatic logic is_bad(input logic [7:0] id);
    return id[7] ? !is_real(id) : (id > ID_RV8);
  endfunction

  function automatic logic [71:0] resolve(input logic [7:0] id, input logic [71:0] rf_val,
                                          input logic hit, input logic [71:0] wb_val,
                                          input logic [63:0] imm, input logic [63:0] rip);
    if (is_real(id)) return hit ? wb_val : rf_val;
    case (id)
      ID_RV8:  return {6'b0, 64'd8};
      ID_RIMM: return {6'b0, imm};
      ID_RIP:  return {6'b0, rip};
      default: return '0;
    endcase
  endfunction

  assign a_real   = is_real(bus.issue_src_a);
  assign b_real   = is_real(bus.issue_src_b);
  assign dst_real = is_real(bus.issue_dst);
  assign wb_real  = bus.wb_valid && is_real(bus.wb_dst);

  always_comb begin
    a_pend   = '0;
    b_pend   = '0;
    dst_pend = '0;
    wb_pend  = '0;
    a_rf     = '0;
    b_rf     = '0;
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      if (bus.issue_src_a[6:0] == 7'(i)) begin
        a_pend = pend_q[i];
        a_rf   = rf_q[i];
      end
      if (bus.issue_src_b[6:0] == 7'(i)) begin
        b_pend = pend_q[i];
        b_rf   = rf_q[i];
      end
      if (bus.issue_dst[6:0] == 7'(i)) dst_pend = pend_q[i];
      if (bus.wb_dst[6:0] == 7'(i))    wb_pend  = pend_q[i];
    end
  end

`ifdef REG_WB_BYPASS_EN
  assign a_hit = a_real && bus.wb_valid && (bus.wb_dst == bus.issue_src_a);
  assign b_hit = b_real && bus.wb_valid && (bus.wb_dst == bus.issue_src_b);
  assign a_ok  = !a_real || (a_pend == '0) || ((a_pend == PEND_W'(1)) && a_hit);
  assign b_ok  = !b_real || (b_pend == '0) || ((b_pend == PEND_W'(1)) && b_hit);
`else
  assign a_hit = 1'b0;
  assign b_hit = 1'b0;
  assign a_ok  = !a_real || (a_pend == '0);
  assign b_ok  = !b_real || (b_pend == '0);
`endif

  // A saturated destination stays blocked even if a writeback drains it this cycle.
  assign dst_ok          = !dst_real || (dst_pend != PEND_MAX);
  assign bus.issue_ready = a_ok && b_ok && dst_ok;
  assign accept          = bus.issue_valid && bus.issue_ready;

  always_comb begin
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      logic inc, dec, hit_wb;
      hit_wb    = wb_real && (bus.wb_dst[6:0] == 7'(i));
      inc       = accept && dst_real && (bus.issue_dst[6:0] == 7'(i));
      dec       = hit_wb && (pend_q[i] != '0);
      rf_d[i]   = hit_wb ? bus.wb_val : rf_q[i];
      pend_d[i] = pend_q[i];
      if (inc && !dec)      pend_d[i] = pend_q[i] + 1'b1;
      else if (dec && !inc) pend_d[i] = pend_q[i] - 1'b1;
    end
  end

  always_comb begin
    op_valid_d   = accept;
    opa_d        = opa_q;
    opb_d        = opb_q;
    if (accept) begin
      opa_d = resolve(bus.issue_src_a, a_rf, a_hit, bus.wb_val, bus.issue_imm, bus.issue_rip);
      opb_d = resolve(bus.issue_src_b, b_rf, b_hit, bus.wb_val, bus.issue_imm, bus.issue_rip);
    end
    err_bad_d    = err_bad_q
                 | (accept && (is_bad(bus.issue_src_a) || is_bad(bus.issue_src_b) || is_bad(bus.issue_dst)))
                 | (bus.wb_valid && is_bad(bus.wb_dst));
    err_unpend_d = err_unpend_q | (wb_real && (wb_pend == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        rf_q[i]   <= '0;
        pend_q[i] <= '0;
      end
      op_valid_q   <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      err_bad_q    <= 1'b0;
      err_unpend_q <= 1'b0;
    end else begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        rf_q[i]   <= rf_d[i];
        pend_q[i] <= pend_d[i];
      end
      op_valid_q   <= op_valid_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      err_bad_q    <= err_bad_d;
      err_unpend_q <= err_unpend_d;
    end
  end

  assign bus.op_valid      = op_valid_q;
  assign bus.opa_val       = opa_q;
  assign bus.opb_val       = opb_q;
  assign bus.err_bad_reg   = err_bad_q;
  assign bus.err_wb_unpend = err_unpend_q;
endmodule

// File: tb/tb_reg_scoreboard_file.sv
// Self-checking bench for reg_scoreboard_file: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_scoreboard_file;
  localparam int         NREG = 20;
  localparam logic [7:0] RNIL = 8'h00, RV0 = 8'h01, RSYSCALL = 8'h02, RIMM = 8'h03, RIP = 8'h04, RV8 = 8'h05;
  localparam logic [7:0] RAX = 8'h80, RCX = 8'h81, RDX = 8'h82, RBX = 8'h83, R8 = 8'h88;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  reg_scoreboard_file_if bus ();
  reg_scoreboard_file #(.REG_FILE_SIZE(NREG), .PEND_W(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Behavioural model and scoreboard
  logic [71:0]  m_rf [NREG];
  int           m_pend [NREG];
  logic         m_err_bad, m_err_unpend, m_opv;
  logic [143:0] exp_q [$];
  logic         obs_ready, exp_ready;
  logic [143:0] exp_ops;

  function automatic logic m_real(input logic [7:0] id);
    return (int'(id) >= 128) && (int'(id) < 128 + NREG);
  endfunction

  function automatic logic m_bad(input logic [7:0] id);
    return !m_real(id) && (id > RV8);
  endfunction

  function automatic int m_idx(input logic [7:0] id);
    return int'(id) - 128;
  endfunction

  function automatic logic [71:0] m_value(input logic [7:0] id);
    if (m_real(id)) begin
`ifdef REG_WB_BYPASS_EN
      if (bus.wb_valid && bus.wb_dst == id) return bus.wb_val;
`endif
      return m_rf[m_idx(id)];
    end
    if (id == RV8)  return {6'b0, 64'd8};
    if (id == RIMM) return {6'b0, bus.issue_imm};
    if (id == RIP)  return {6'b0, bus.issue_rip};
    return 72'd0;
  endfunction

  function automatic logic m_src_ok(input logic [7:0] id);
    if (!m_real(id)) return 1'b1;
    if (m_pend[m_idx(id)] == 0) return 1'b1;
`ifdef REG_WB_BYPASS_EN
    if (m_pend[m_idx(id)] == 1 && bus.wb_valid && bus.wb_dst == id) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic m_ready();
    return m_src_ok(bus.issue_src_a) && m_src_ok(bus.issue_src_b)
        && (!m_real(bus.issue_dst) || m_pend[m_idx(bus.issue_dst)] < 3);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_rf[i]   = 72'd0;
      m_pend[i] = 0;
    end
    m_err_bad = 1'b0;
    m_err_unpend = 1'b0;
    m_opv = 1'b0;
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_src_a = RNIL;
    bus.issue_src_b = RNIL;
    bus.issue_dst   = RNIL;
    bus.issue_imm   = 64'd0;
    bus.issue_rip   = 64'd0;
    bus.wb_valid    = 1'b0;
    bus.wb_dst      = RNIL;
    bus.wb_val      = 72'd0;
  endtask

  task automatic set_issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    bus.issue_valid = 1'b1;
    bus.issue_src_a = a;
    bus.issue_src_b = b;
    bus.issue_dst   = d;
  endtask

  task automatic set_wb(input logic [7:0] d, input logic [71:0] v);
    bus.wb_valid = 1'b1;
    bus.wb_dst   = d;
    bus.wb_val   = v;
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Samples issue_ready, advances the model over the coming edge, and returns 1 ns after it.
  task automatic tick();
    logic acc;
    int   k;
    #1;
    obs_ready = bus.issue_ready;
    exp_ready = m_ready();
    acc = bus.issue_valid && exp_ready;
    if (acc) begin
      exp_q.push_back({m_value(bus.issue_src_a), m_value(bus.issue_src_b)});
      if (m_bad(bus.issue_src_a) || m_bad(bus.issue_src_b) || m_bad(bus.issue_dst)) m_err_bad = 1'b1;
    end
    if (bus.wb_valid) begin
      if (m_bad(bus.wb_dst)) m_err_bad = 1'b1;
      if (m_real(bus.wb_dst)) begin
        k = m_idx(bus.wb_dst);
        if (m_pend[k] == 0) m_err_unpend = 1'b1;
        else m_pend[k] = m_pend[k] - 1;
        m_rf[k] = bus.wb_val;
      end
    end
    if (acc && m_real(bus.issue_dst)) m_pend[m_idx(bus.issue_dst)] += 1;
    m_opv = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_cnt++; if (bus.op_valid !== 1'b0) $display("FAIL reset_op_valid: got %0b want 0", bus.op_valid); else pass_cnt++;
    check_cnt++; if (bus.opa_val !== 72'd0) $display("FAIL reset_opa: got %h want 0", bus.opa_val); else pass_cnt++;
    check_cnt++; if (bus.opb_val !== 72'd0) $display("FAIL reset_opb: got %h want 0", bus.opb_val); else pass_cnt++;
    check_cnt++; if (bus.err_bad_reg !== 1'b0 || bus.err_wb_unpend !== 1'b0)
      $display("FAIL reset_errs: got %0b%0b want 00", bus.err_bad_reg, bus.err_wb_unpend); else pass_cnt++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_issue(RAX, RV8, RNIL);
    tick();
    check_cnt++; if (obs_ready !== 1'b1) $display("FAIL reset_first_ready: got %0b want 1", obs_ready); else pass_cnt++;
    check_cnt++; if (bus.op_valid !== 1'b1) $display("FAIL reset_first_op_valid: got %0b want 1", bus.op_valid); else pass_cnt++;
    check_cnt++; if (bus.opa_val !== 72'd0) $display("FAIL reset_rax: got %h want 0", bus.opa_val); else pass_cnt++;
    check_cnt++; if (bus.opb_val !== {6'b0, 64'd8}) $display("FAIL reset_rv8: got %h want 8", bus.opb_val); else pass_cnt++;
    idle();
    tick();
    check_cnt++; if (bus.op_valid !== 1'b0 || bus.opb_val !== {6'b0, 64'd8})
      $display("FAIL idle_hold: op_valid=%0b opb=%h want 0 and 8", bus.op_valid, bus.opb_val); else pass_cnt++;
  endtask

  task automatic test_raw();
    logic [71:0] v;
    v = {1'b1, 5'b0, 64'hDEAD};
    apply_reset();
    set_issue(RNIL, RNIL, RCX);
    tick();
    idle();
    set_issue(RCX, RNIL, RNIL);
    tick();
    check_cnt++; if (obs_ready !== 1'b0) $display("FAIL raw_stall: issue_ready=%0b want 0", obs_ready); else pass_cnt++;
    set_wb(RCX, v);
    tick();
`ifdef REG_WB_BYPASS_EN
    check_cnt++; if (obs_ready !== 1'b1) $display("FAIL raw_bypass_ready: got %0b want 1", obs_ready); else pass_cnt++;
`else
    check_cnt++; if (obs_ready !== 1'b0) $display("FAIL raw_wb_edge_ready: got %0b want 0", obs_ready); else pass_cnt++;
    bus.wb_valid = 1'b0;
    tick();
    check_cnt++; if (obs_ready !== 1'b1) $display("FAIL raw_after_wb_ready: got %0b want 1", obs_ready); else pass_cnt++;
`endif
    check_cnt++; if (bus.op_valid !== 1'b1 || bus.opa_val !== v)
      $display("FAIL raw_value: op_valid=%0b opa=%h want 1 and %h", bus.op_valid, bus.opa_val, v); else pass_cnt++;
  endtask

  task automatic test_waw();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_issue(RNIL, RNIL, R8);
      tick();
      check_cnt++; if (obs_ready !== 1'b1) $display("FAIL waw_fill%0d: issue_ready=%0b want 1", i, obs_ready); else pass_cnt++;
    end
    tick();
    check_cnt++; if (obs_ready !== 1'b0) $display("FAIL waw_full: issue_ready=%0b want 0", obs_ready); else pass_cnt++;
    set_wb(R8, 72'h5A);
    tick();
    check_cnt++; if (obs_ready !== 1'b0) $display("FAIL waw_full_wb: issue_ready=%0b want 0", obs_ready); else pass_cnt++;
    bus.wb_valid = 1'b0;
    tick();
    check_cnt++; if (obs_ready !== 1'b1 || bus.op_valid !== 1'b1)
      $display("FAIL waw_drain: ready=%0b op_valid=%0b want 1 1", obs_ready, bus.op_valid); else pass_cnt++;
  endtask

  task automatic test_fake();
    apply_reset();
    set_issue(RIMM, RIP, RNIL);
    bus.issue_imm = 64'h1234;
    bus.issue_rip = 64'h400000;
    tick();
    check_cnt++; if (bus.opa_val !== {6'b0, 64'h1234}) $display("FAIL fake_imm: got %h want 1234", bus.opa_val); else pass_cnt++;
    check_cnt++; if (bus.opb_val !== {6'b0, 64'h400000}) $display("FAIL fake_rip: got %h want 400000", bus.opb_val); else pass_cnt++;
    set_issue(RV0, RSYSCALL, RNIL);
    tick();
    check_cnt++; if (bus.opa_val !== 72'd0 || bus.opb_val !== 72'd0)
      $display("FAIL fake_zero: opa=%h opb=%h want 0 0", bus.opa_val, bus.opb_val); else pass_cnt++;
    check_cnt++; if (bus.err_bad_reg !== 1'b0) $display("FAIL fake_no_err: got %0b want 0", bus.err_bad_reg); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [71:0] v;
    v = {1'b0, 1'b1, 4'b0, 64'hCAFE_F00D};
    apply_reset();
    set_issue(8'h94, RV8, RNIL);
    tick();
    check_cnt++; if (bus.err_bad_reg !== 1'b1) $display("FAIL err_bad_src: got %0b want 1", bus.err_bad_reg); else pass_cnt++;
    check_cnt++; if (bus.opa_val !== 72'd0) $display("FAIL err_bad_operand: got %h want 0", bus.opa_val); else pass_cnt++;
    idle();
    set_wb(RDX, v);
    tick();
    check_cnt++; if (bus.err_wb_unpend !== 1'b1) $display("FAIL err_unpend: got %0b want 1", bus.err_wb_unpend); else pass_cnt++;
    idle();
    set_issue(RDX, RNIL, RNIL);
    tick();
    check_cnt++; if (bus.opa_val !== v) $display("FAIL err_unpend_write: got %h want %h", bus.opa_val, v); else pass_cnt++;
    apply_reset();
    set_wb(8'h06, 72'h1);
    tick();
    check_cnt++; if (bus.err_bad_reg !== 1'b1 || bus.err_wb_unpend !== 1'b0)
      $display("FAIL err_wb_fake: bad=%0b unpend=%0b want 1 0", bus.err_bad_reg, bus.err_wb_unpend); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_issue(RNIL, RV8, RBX);
    tick();
    tick();
    set_issue(RBX, RNIL, RNIL);
    tick();
    check_cnt++; if (obs_ready !== 1'b0) $display("FAIL mid_stall: issue_ready=%0b want 0", obs_ready); else pass_cnt++;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_cnt++; if (bus.opb_val !== 72'd0) $display("FAIL mid_async_clear: opb=%h want 0", bus.opb_val); else pass_cnt++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check_cnt++; if (obs_ready !== 1'b1 || bus.opa_val !== 72'd0)
      $display("FAIL mid_release: ready=%0b opa=%h want 1 0", obs_ready, bus.opa_val); else pass_cnt++;
    idle();
    set_wb(RBX, 72'h77);
    tick();
    check_cnt++; if (bus.err_wb_unpend !== 1'b1) $display("FAIL mid_stale_wb: got %0b want 1", bus.err_wb_unpend); else pass_cnt++;
  endtask

  function automatic logic [7:0] rand_id();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 8'h80 + 8'($urandom_range(0, 5));
    if (r < 19) return 8'($urandom_range(0, 5));
    case ($urandom_range(0, 2))
      0:       return 8'h94;
      1:       return 8'h06;
      default: return 8'h9F;
    endcase
  endfunction

  task automatic test_random();
    int k;
    for (int c = 0; c < 800; c++) begin
      if (c % 200 == 0) apply_reset();
      bus.issue_valid = ($urandom_range(0, 3) != 0);
      bus.issue_src_a = rand_id();
      bus.issue_src_b = rand_id();
      bus.issue_dst   = rand_id();
      bus.issue_imm   = {$urandom, $urandom};
      bus.issue_rip   = {$urandom, $urandom};
      bus.wb_valid    = ($urandom_range(0, 2) != 0);
      k = $urandom_range(0, 5);
      bus.wb_dst      = (m_pend[k] > 0 || $urandom_range(0, 3) == 0) ? 8'h80 + 8'(k) : rand_id();
      bus.wb_val      = {6'($urandom), $urandom, $urandom};
      tick();
      check_cnt++; if (obs_ready !== exp_ready) $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, obs_ready, exp_ready); else pass_cnt++;
      check_cnt++; if (bus.op_valid !== m_opv) $display("FAIL rnd_op_valid c=%0d: got %0b want %0b", c, bus.op_valid, m_opv); else pass_cnt++;
      if (m_opv) begin
        exp_ops = (exp_q.size() > 0) ? exp_q.pop_front() : 144'd0;
        check_cnt++; if ({bus.opa_val, bus.opb_val} !== exp_ops)
          $display("FAIL rnd_ops c=%0d: got %h %h want %h %h", c, bus.opa_val, bus.opb_val, exp_ops[143:72], exp_ops[71:0]);
          else pass_cnt++;
      end
      check_cnt++; if ({bus.err_bad_reg, bus.err_wb_unpend} !== {m_err_bad, m_err_unpend})
        $display("FAIL rnd_errs c=%0d: got %0b%0b want %0b%0b", c, bus.err_bad_reg, bus.err_wb_unpend, m_err_bad, m_err_unpend);
        else pass_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Final report
  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_fake();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
